// File: rtl/esfa_pkg.sv
// Shared types and constants for the ESFA operation sequencer: FSM state
// encoding, the cell-array NOP selector and the 8-bit command field width.
package esfa_pkg;

  localparam int FIELD_W = 8;

  localparam logic [FIELD_W-1:0] SEL_NOP = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/esfa_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the requests;
// the last-granted pointer only moves when the sequencer accepts a command.
module esfa_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last <= 1'b1;
    end else if (accept) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/esfa_op_sequencer.sv
// Two-requester command sequencer for the ESFA cell array: arbitrate, issue,
// wait for the combinator-tree root, return a response. Optional WAIT timeout
// is enabled by defining ESFA_SEQ_TIMEOUT_EN.
module esfa_op_sequencer
  import esfa_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CYC_W          = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rq0_valid,
  output logic               rq0_ready,
  input  logic [FIELD_W-1:0] rq0_sel,
  input  logic [FIELD_W-1:0] rq0_index,
  input  logic [FIELD_W-1:0] rq0_value,
  input  logic [FIELD_W-1:0] rq0_meta,
  input  logic               rq0_is_meta,
  input  logic               rq1_valid,
  output logic               rq1_ready,
  input  logic [FIELD_W-1:0] rq1_sel,
  input  logic [FIELD_W-1:0] rq1_index,
  input  logic [FIELD_W-1:0] rq1_value,
  input  logic [FIELD_W-1:0] rq1_meta,
  input  logic               rq1_is_meta,
  output logic [FIELD_W-1:0] arr_sel,
  output logic [FIELD_W-1:0] arr_index,
  output logic [FIELD_W-1:0] arr_value,
  output logic [FIELD_W-1:0] arr_meta,
  output logic               arr_is_meta,
  input  logic               arr_done,
  input  logic               arr_bool,
  input  logic [FIELD_W-1:0] arr_value_in,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic               rsp_bool,
  output logic [FIELD_W-1:0] rsp_value,
  output logic               rsp_err,
  output logic [CYC_W-1:0]   rsp_cycles
);

`ifdef ESFA_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [CYC_W-1:0] CNT_MAX     = '1;
  localparam logic [CYC_W-1:0] TIMEOUT_LIM = CYC_W'(TIMEOUT_CYCLES);

  seq_state_t         state;
  logic               cmd_id;
  logic [CYC_W-1:0]   cnt;
  logic [1:0]         req;
  logic [1:0]         grant;
  logic               accept;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CYC_W'(1);
  endfunction

  assign req    = {rq1_valid, rq0_valid};
  assign accept = (state == S_IDLE) && reset && (|req);

  // Ready is the handshake strobe for the accepting edge, so it cannot lag by a register.
  assign rq0_ready = accept && grant[0];
  assign rq1_ready = accept && grant[1];

  esfa_rr_arb2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmd_id      <= 1'b0;
      cnt         <= '0;
      arr_sel     <= SEL_NOP;
      arr_index   <= '0;
      arr_value   <= '0;
      arr_meta    <= '0;
      arr_is_meta <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_bool    <= 1'b0;
      rsp_value   <= '0;
      rsp_err     <= 1'b0;
      rsp_cycles  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            cmd_id      <= grant[1];
            arr_sel     <= grant[1] ? rq1_sel     : rq0_sel;
            arr_index   <= grant[1] ? rq1_index   : rq0_index;
            arr_value   <= grant[1] ? rq1_value   : rq0_value;
            arr_meta    <= grant[1] ? rq1_meta    : rq0_meta;
            arr_is_meta <= grant[1] ? rq1_is_meta : rq0_is_meta;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CYC_W'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the timeout cycle still completes normally.
          if (arr_done) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cmd_id;
            rsp_bool    <= arr_bool;
            rsp_value   <= arr_value_in;
            rsp_err     <= 1'b0;
            rsp_cycles  <= cnt;
            arr_sel     <= SEL_NOP;
            arr_is_meta <= 1'b0;
            state       <= S_RESP;
          end else if (TIMEOUT_EN && (cnt >= TIMEOUT_LIM)) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= cmd_id;
            rsp_bool    <= 1'b0;
            rsp_value   <= '0;
            rsp_err     <= 1'b1;
            rsp_cycles  <= TIMEOUT_LIM;
            arr_sel     <= SEL_NOP;
            arr_is_meta <= 1'b0;
            state       <= S_RESP;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/esfa_op_sequencer.md
ESFA_OP_SEQUENCER -- requirements
Module: esfa_op_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning max WAIT cycles before abort (range 1..2^CYC_W-1).
REQ-002 SHALL have parameter CYC_W, default 16, meaning width of cycle counter and rsp_cycles.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have ports rq0_valid/rq1_valid  input  1  requester n has a command pending.
REQ-006 SHALL have ports rq0_ready/rq1_ready  output  1  command accepted this cycle.
REQ-007 SHALL have ports rqN_sel, rqN_index, rqN_value, rqN_meta  input  8 each  opcode selector, index, value, metadata (N = 0, 1).
REQ-008 SHALL have ports rqN_is_meta  input  1  metadata-write flag.
REQ-009 SHALL have ports arr_sel, arr_index, arr_value, arr_meta  output  8 each  drive to cell array.
REQ-010 SHALL have port arr_is_meta  output  1  drive to cell array.
REQ-011 SHALL have ports arr_done  input  1, arr_bool  input  1, arr_value_in  input  8  array combinator-tree root outputs.
REQ-012 SHALL have ports rsp_valid  output  1, rsp_ready  input  1, rsp_id  output  1, rsp_bool  output  1, rsp_value  output  8, rsp_err  output  1, rsp_cycles  output  CYC_W.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-014 IDLE: if any rqN_valid, SHALL assert that port's rqN_ready for exactly one cycle, latch its command, and go to ISSUE next cycle.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the port not granted last; with one valid, grant it; never assert both readies.
REQ-016 ISSUE: SHALL drive latched command on arr_* for one cycle, clear cycle counter to 1, ignore arr_done, go to WAIT.
REQ-017 WAIT: SHALL hold arr_* stable, increment counter each cycle, and on arr_done=1 capture arr_bool, arr_value_in, counter into rsp_* and go to RESP.
REQ-018 Cycle counter SHALL saturate at 2^CYC_W-1, never wrap.
REQ-019 RESP: SHALL hold rsp_valid=1 with stable rsp_* until rsp_valid&&rsp_ready, then go to IDLE on the next cycle.
REQ-020 In IDLE and RESP, arr_sel SHALL be 8'h00 (NOP) and arr_is_meta 0; arr_index/value/meta hold last values.
REQ-021 rq*_ready SHALL be 0 in every state except IDLE; new requests wait while busy.
REQ-022 rsp_id SHALL equal the granted port; rsp_err 0 on normal completion.
REQ-023 arr_done asserting in same cycle as timeout SHALL count as normal completion (done wins).

Reset
REQ-024 While reset=0 at a clock edge: state IDLE, rr pointer = port 1 (so port 0 wins first tie), counter 0.
REQ-025 Reset values: rq*_ready 0, arr_* 0, rsp_valid 0, rsp_id 0, rsp_bool 0, rsp_value 0, rsp_err 0, rsp_cycles 0.
REQ-026 Reset mid-operation SHALL abandon the command with no response and drive arr_sel NOP the following cycle.

Configuration
REQ-027 With ESFA_SEQ_TIMEOUT_EN defined: WAIT reaching TIMEOUT_CYCLES without arr_done SHALL go to RESP with rsp_err=1, rsp_bool 0, rsp_value 8'h00, rsp_cycles=TIMEOUT_CYCLES.
REQ-028 Without ESFA_SEQ_TIMEOUT_EN: no timeout logic; WAIT persists until arr_done; rsp_err tied 0.

Structure
REQ-029 Shared package esfa_pkg SHALL hold state enum, NOP selector constant (8'h00), and 8-bit field widths.
REQ-030 Arbiter SHALL be one sub-module esfa_rr_arb2 (2-way round-robin, grant-pointer update on accept).

Verification
REQ-031 Single req: rq0 sel=8'h03 index=5 value=8'h2A; arr_done after 4 WAIT cycles, arr_value_in=8'h2A, bool 1 -> rsp_id 0, rsp_value 8'h2A, rsp_bool 1, rsp_cycles 5, rsp_err 0.
REQ-032 Both valid from reset, three commands each -> grant order 0,1,0,1,0,1; never both ready.
REQ-033 rsp_ready held 0 for 10 cycles in RESP -> rsp_* stable, rq*_ready stays 0, arr_sel 8'h00.
REQ-034 Timeout (macro on, TIMEOUT_CYCLES=8, arr_done never) -> RESP with rsp_err 1, rsp_cycles 8; arr_done on cycle 8 -> rsp_err 0.
REQ-035 reset=0 during WAIT -> next cycle state IDLE, rsp_valid 0, arr_sel 8'h00; subsequent rq1 command completes normally.
REQ-036 CYC_W=4, arr_done after 20 cycles (macro off) -> rsp_cycles 4'hF.
